// File: rtl/inst_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: instruction width,
// PC increment and fetch FSM state encodings.
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif
`ifndef PC_INCR
`define PC_INCR 4
`endif
`ifndef FETCH_IDLE
`define FETCH_IDLE 1'b0
`endif
`ifndef FETCH_RUN
`define FETCH_RUN 1'b1
`endif

package inst_fetch_unit_pkg;

    localparam int INST_W  = `INST_WIDTH;
    localparam int PC_INCR = `PC_INCR;

    typedef enum logic {
        ST_IDLE = `FETCH_IDLE,
        ST_RUN  = `FETCH_RUN
    } fetch_state_e;

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Instruction-memory read port plus the decode-side valid/ready stream.
interface inst_fetch_unit_if #(
    parameter int ADDR_WIDTH = 10
);
    import inst_fetch_unit_pkg::*;

    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [INST_W-1:0]     imem_inst;
    logic                  out_valid;
    logic                  out_ready;
    logic [INST_W-1:0]     out_inst;
    logic [ADDR_WIDTH-1:0] out_pc;

    // Fetch unit side
    modport master (
        output imem_addr,
        input  imem_inst,
        output out_valid,
        input  out_ready,
        output out_inst,
        output out_pc
    );

    // Memory / decode side
    modport slave (
        input  imem_addr,
        output imem_inst,
        input  out_valid,
        output out_ready,
        input  out_inst,
        input  out_pc
    );

endinterface

// File: rtl/inst_fetch_unit_fetch_fifo.sv
// Small synchronous FIFO with flush. The head entry is read straight out of
// the storage registers, so the head outputs are registered.
module fetch_fifo #(
    parameter int WIDTH = 42,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    // A push into a full FIFO is only accepted alongside a pop.
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    // Storage, pointers and occupancy; flush empties without touching data.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, reads instruction memory and
// buffers {pc, inst} pairs for decode. Redirects load a new word-aligned PC
// and flush anything already buffered.
//
// state | meaning
// IDLE  | no fetches issued; buffered entries still drain to decode
// RUN   | one fetch per cycle whenever the buffer can take it
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 10,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_en,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    inst_fetch_unit_if.master     bus
);
    fetch_state_e          state;
    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic                  push;
    logic                  pop;
    logic                  full;
    logic                  empty;
    logic [ADDR_WIDTH+INST_W-1:0] head;

    assign bus.imem_addr = fetch_pc;
    assign bus.out_valid = ~empty;
    assign bus.out_pc    = head[ADDR_WIDTH+INST_W-1:INST_W];
    assign bus.out_inst  = head[INST_W-1:0];

    assign pop  = bus.out_valid & bus.out_ready;
    assign push = (state == ST_RUN) & fetch_en & ~redirect_valid & (~full | pop);

    // Fetch FSM and PC; redirect takes priority over sequential fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            fetch_pc <= RESET_PC;
        end else begin
            state <= fetch_en ? ST_RUN : ST_IDLE;
            if (redirect_valid) begin
                fetch_pc <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
            end else if (push) begin
                fetch_pc <= fetch_pc + ADDR_WIDTH'(PC_INCR);
            end
        end
    end

    fetch_fifo #(
        .WIDTH (ADDR_WIDTH + INST_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .din   ({fetch_pc, bus.imem_inst}),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: a table of per-cycle stimulus and
// expected outputs, followed by short hand-written multi-cycle sequences.
module tb_inst_fetch_unit;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          fetch_en;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;

    int n_cmp = 0;
    int n_err = 0;

    inst_fetch_unit_if #(.ADDR_WIDTH(AW)) ifc ();

    inst_fetch_unit #(
        .ADDR_WIDTH (AW),
        .RESET_PC   ('0),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .bus            (ifc)
    );

    always #5 clk = ~clk;

    // Instruction memory: word i holds A000_0000 | i.
    assign ifc.imem_inst = 32'hA000_0000 | 32'(ifc.imem_addr >> 2);

    typedef struct {
        logic          rst;
        logic          en;
        logic          rv;
        logic [AW-1:0] rpc;
        logic          rdy;
        logic          ev;
        logic [AW-1:0] epc;
        logic [AW-1:0] eaddr;
        logic          chk_head;
    } vec_t;

    vec_t tbl [21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Apply one cycle of stimulus, then check outputs just after the edge.
    task automatic step(input string tag, input vec_t v);
        logic [31:0] einst;
        @(negedge clk);
        rst            = v.rst;
        fetch_en       = v.en;
        redirect_valid = v.rv;
        redirect_pc    = v.rpc;
        ifc.out_ready  = v.rdy;
        @(posedge clk);
        #1;
        chk({tag, " out_valid"}, 32'(ifc.out_valid), 32'(v.ev));
        chk({tag, " imem_addr"}, 32'(ifc.imem_addr), 32'(v.eaddr));
        if (v.chk_head) begin
            einst = v.ev ? (32'hA000_0000 | 32'(v.epc >> 2)) : 32'h0;
            chk({tag, " out_pc"},   32'(ifc.out_pc), 32'(v.epc));
            chk({tag, " out_inst"}, ifc.out_inst,    einst);
        end
    endtask

    function automatic vec_t mk(logic r, logic e, logic rv, logic [AW-1:0] rpc, logic rdy,
                                logic ev, logic [AW-1:0] epc, logic [AW-1:0] ea, logic ch);
        vec_t v;
        v.rst = r; v.en = e; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
        v.ev = ev; v.epc = epc; v.eaddr = ea; v.chk_head = ch;
        return v;
    endfunction

    initial begin
        rst            = 1'b1;
        fetch_en       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        ifc.out_ready  = 1'b0;

        //             rst en rv rpc     rdy ev epc     eaddr   chk
        tbl[0]  = mk(1, 0, 0, 10'h000, 0, 0, 10'h000, 10'h000, 1);
        tbl[1]  = mk(1, 1, 0, 10'h000, 1, 0, 10'h000, 10'h000, 1);
        tbl[2]  = mk(0, 1, 0, 10'h000, 1, 0, 10'h000, 10'h000, 0);
        tbl[3]  = mk(0, 1, 0, 10'h000, 1, 1, 10'h000, 10'h004, 1);
        tbl[4]  = mk(0, 1, 0, 10'h000, 1, 1, 10'h004, 10'h008, 1);
        tbl[5]  = mk(0, 1, 0, 10'h000, 1, 1, 10'h008, 10'h00C, 1);
        tbl[6]  = mk(0, 1, 0, 10'h000, 0, 1, 10'h008, 10'h010, 1);
        tbl[7]  = mk(0, 1, 0, 10'h000, 0, 1, 10'h008, 10'h010, 1);
        tbl[8]  = mk(0, 1, 0, 10'h000, 0, 1, 10'h008, 10'h010, 1);
        tbl[9]  = mk(0, 1, 0, 10'h000, 0, 1, 10'h008, 10'h010, 1);
        tbl[10] = mk(0, 1, 0, 10'h000, 0, 1, 10'h008, 10'h010, 1);
        tbl[11] = mk(0, 1, 0, 10'h000, 1, 1, 10'h00C, 10'h014, 1);
        tbl[12] = mk(0, 1, 0, 10'h000, 1, 1, 10'h010, 10'h018, 1);
        tbl[13] = mk(0, 1, 1, 10'h103, 1, 0, 10'h000, 10'h100, 0);
        tbl[14] = mk(0, 1, 0, 10'h000, 1, 1, 10'h100, 10'h104, 1);
        tbl[15] = mk(0, 1, 0, 10'h000, 1, 1, 10'h104, 10'h108, 1);
        tbl[16] = mk(0, 1, 1, 10'h3F8, 1, 0, 10'h000, 10'h3F8, 0);
        tbl[17] = mk(0, 1, 0, 10'h000, 1, 1, 10'h3F8, 10'h3FC, 1);
        tbl[18] = mk(0, 1, 0, 10'h000, 1, 1, 10'h3FC, 10'h000, 1);
        tbl[19] = mk(0, 1, 0, 10'h000, 1, 1, 10'h000, 10'h004, 1);
        tbl[20] = mk(0, 1, 0, 10'h000, 1, 1, 10'h004, 10'h008, 1);

        for (int i = 0; i < 21; i++) begin
            step($sformatf("vec%0d", i), tbl[i]);
        end

        // fetch_en drop with two entries buffered: drain, hold PC, resume.
        step("fill2",   mk(0, 1, 0, 10'h000, 0, 1, 10'h004, 10'h00C, 1));
        step("drain1",  mk(0, 0, 0, 10'h000, 1, 1, 10'h008, 10'h00C, 1));
        step("drain2",  mk(0, 0, 0, 10'h000, 1, 0, 10'h000, 10'h00C, 0));
        step("idle",    mk(0, 0, 0, 10'h000, 1, 0, 10'h000, 10'h00C, 0));
        step("reen",    mk(0, 1, 0, 10'h000, 1, 0, 10'h000, 10'h00C, 0));
        step("resume",  mk(0, 1, 0, 10'h000, 1, 1, 10'h00C, 10'h010, 1));

        // Reset while full and redirecting: reset wins, restart from RESET_PC.
        step("refill",  mk(0, 1, 0, 10'h000, 0, 1, 10'h00C, 10'h014, 1));
        step("rst_mid", mk(1, 1, 1, 10'h200, 1, 0, 10'h000, 10'h000, 1));
        step("restart", mk(0, 1, 0, 10'h000, 1, 0, 10'h000, 10'h000, 0));
        step("first",   mk(0, 1, 0, 10'h000, 1, 1, 10'h000, 10'h004, 1));
        step("second",  mk(0, 1, 0, 10'h000, 1, 1, 10'h004, 10'h008, 1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Initiator side of the instruction-memory read interface.
- Owns the fetch PC and drives the byte address into `instruction_memory`, which returns the instruction combinationally in the same cycle.
- Captures {pc, inst} pairs into a small flushable FIFO and presents them to decode through a valid/ready handshake.
- Handles stall (backpressure), fetch enable, and branch/jump redirect with flush.

Parameters:
- ADDR_WIDTH, 10, byte-address width; equals $clog2(MEM_SIZE) of the attached instruction memory.
- RESET_PC, 0, fetch PC loaded on reset; must be 4-byte aligned.
- FIFO_DEPTH, 2, entries in the fetch buffer; power of two, at least 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- fetch_en  input  1  allows new fetches when high.
- imem_addr  output  ADDR_WIDTH  byte address to the instruction memory; equals fetch_pc combinationally.
- imem_inst  input  `INST_WIDTH  instruction returned combinationally for imem_addr.
- redirect_valid  input  1  branch/jump taken; load redirect_pc.
- redirect_pc  input  ADDR_WIDTH  new fetch byte address.
- out_valid  output  1  FIFO head holds a valid instruction.
- out_ready  input  1  decode accepts the head this cycle.
- out_inst  output  `INST_WIDTH  instruction at FIFO head.
- out_pc  output  ADDR_WIDTH  byte address of out_inst.

Behaviour:
- Reset (rst high at an edge):
  - fetch_pc=RESET_PC, FIFO emptied, state=IDLE.
  - out_valid=0; out_inst=0 and out_pc=0 (head storage cleared).
  - Reset overrides redirect, push and pop in the same cycle.
- State machine, two states:
  - IDLE: no pushes. Go to RUN on an edge where fetch_en=1.
  - RUN: pushes allowed. Go to IDLE on an edge where fetch_en=0; the FIFO keeps draining while in IDLE.
  - The IDLE->RUN edge does not push. The first push is on the next edge, so the first out_valid appears 2 edges after fetch_en rises out of reset.
- pop = out_valid & out_ready.
- push = (state==RUN) & fetch_en & !redirect_valid & (!full | pop).
  - Push and pop in the same cycle on a full FIFO is legal; occupancy is unchanged.
- On push:
  - FIFO writes {fetch_pc, imem_inst}.
  - fetch_pc <= fetch_pc + 4, wrapping modulo 2^ADDR_WIDTH (0x3FC -> 0x000 at default width).
- fetch_pc holds whenever there is no push and no redirect.
- Redirect (redirect_valid=1 at an edge, rst=0):
  - FIFO flushed to empty; any simultaneous pop is discarded.
  - No push that cycle.
  - fetch_pc <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00}; low bits are forced to zero.
  - out_valid=0 for exactly one cycle after the edge when in RUN with fetch_en=1.
  - First post-redirect instruction: out_pc = aligned redirect_pc.
  - Redirect is honoured in IDLE as well (PC load plus flush).
- out_valid = !empty; out_inst and out_pc are driven from the FIFO head register.
  - Outputs stay stable while out_valid=1 and out_ready=0.
- Occupancy counter width is $clog2(FIFO_DEPTH)+1.
  - full = (count==FIFO_DEPTH); empty = (count==0).
  - Read and write pointers wrap modulo FIFO_DEPTH.
- The block never issues a push while full without a simultaneous pop, so no entry is overwritten.

Decomposition:
- definitions.vh (existing header) supplies `INST_WIDTH.
- Add to definitions.vh: `PC_INCR (4) and `FETCH_IDLE / `FETCH_RUN state encodings (1 bit).
- One sub-module: fetch_fifo.
  - Synchronous FIFO, parameterised width/depth, with push, pop, flush, full, empty.
  - Registered head output.
  - Shares clk/rst with the parent.
- The top level holds the PC, the FSM and the push/redirect logic.

Test Plan:
- Memory word i = 32'hA000_0000 | i; hold rst for 2 cycles, then fetch_en=1 and out_ready=1.
  - Stream out_pc=0x000,0x004,0x008… with out_inst=A0000000,A0000001,A0000002…
  - First out_valid 2 edges after fetch_en rises.
- Backpressure: out_ready=0 for 5 cycles mid-stream.
  - FIFO fills to 2 and imem_addr freezes.
  - out_inst/out_pc stay stable.
  - On out_ready=1, the stream resumes with no skipped or duplicated pc.
- Redirect to 0x103 while the FIFO holds 2 entries and out_ready=1.
  - Next cycle out_valid=0.
  - Following output: out_pc=0x100, out_inst=A0000040; stale entries are never seen.
- Wrap: redirect to 0x3F8.
  - Outputs pc 0x3F8, 0x3FC, 0x000, 0x004 with matching instructions.
- fetch_en drop: deassert fetch_en with 2 entries buffered.
  - Both drain, then out_valid=0 and imem_addr holds.
  - Re-enable: fetching continues from the held pc after one IDLE->RUN cycle.
- Reset mid-operation: assert rst for 1 cycle while full and with redirect_valid=1.
  - out_valid=0 next cycle.
  - First output after restart has out_pc=RESET_PC.
